// File: rtl/stall_flush_unit.sv
// -----------------------------------------------------------------------------
// stall_flush_unit
// Pipeline stall/flush controller that works next to the operand-forwarding
// logic. It covers the cases forwarding cannot:
//   * load-use hazard: a load in E feeding a source register in D
//     -> hold F and D for one cycle and bubble E
//   * taken branch/jump in E
//     -> clear the two wrong-path instructions in D and E
//   * data memory in M not ready
//     -> freeze the whole pipe and bubble W
// Hazard outputs are combinational and act in the same cycle. The
// memory-wait FSM, the timeout flag and the performance counters are
// registered.
//
// Ports
//   clk_i, rst_i        clock (rising edge), synchronous active-high reset
//   rs1D_i, rs2D_i      source registers of the instruction in D
//   rdE_i               destination register of the instruction in E
//   mem_readE_i         instruction in E is a load
//   pc_srcE_i           branch/jump taken in E
//   mem_reqM_i          data memory access active in M
//   mem_readyM_i        data memory completes its access this cycle
//   stallF/D/E/M_o      hold PC, F/D, D/E and E/M registers
//   flushD_o, flushE_o  clear F/D and D/E registers
//   flushW_o            insert a bubble into the M/W register
//   mem_err_o           sticky memory-timeout flag, cleared only by reset
//   stall_cnt_o         cycles with stallF_o=1 (saturating)
//   flush_cnt_o         taken-branch flush cycles (saturating)
// -----------------------------------------------------------------------------
module stall_flush_unit #(
   parameter int ADDR_WIDTH = 5,
   parameter int TIMEOUT    = 64,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [ADDR_WIDTH-1:0] rs1D_i,
   input  logic [ADDR_WIDTH-1:0] rs2D_i,
   input  logic [ADDR_WIDTH-1:0] rdE_i,
   input  logic                  mem_readE_i,
   input  logic                  pc_srcE_i,
   input  logic                  mem_reqM_i,
   input  logic                  mem_readyM_i,
   output logic                  stallF_o,
   output logic                  stallD_o,
   output logic                  stallE_o,
   output logic                  stallM_o,
   output logic                  flushD_o,
   output logic                  flushE_o,
   output logic                  flushW_o,
   output logic                  mem_err_o,
   output logic [CNT_WIDTH-1:0]  stall_cnt_o,
   output logic [CNT_WIDTH-1:0]  flush_cnt_o
);

   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [WAIT_W-1:0]     wait_q;
   logic                  err_q;
   logic [CNT_WIDTH-1:0]  stall_cnt_q;
   logic [CNT_WIDTH-1:0]  flush_cnt_q;
   logic                  freeze;
   logic                  lduse;

   // A pending, not-ready memory access freezes the pipe in either state.
   assign freeze = mem_reqM_i & ~mem_readyM_i;
   assign lduse  = mem_readE_i & (rdE_i != '0) &
                   ((rdE_i == rs1D_i) | (rdE_i == rs2D_i));

   // Next-state and hazard outputs.
   always_comb begin
      state_d  = state_q;
      stallF_o = 1'b0;
      stallD_o = 1'b0;
      stallE_o = 1'b0;
      stallM_o = 1'b0;
      flushD_o = 1'b0;
      flushE_o = 1'b0;
      flushW_o = 1'b0;

      unique case (state_q)
         RUN:      if (freeze) state_d = MEM_WAIT;
         // A ready pulse without an active request is meaningless and ignored.
         MEM_WAIT: if (mem_reqM_i & mem_readyM_i) state_d = RUN;
         default:  state_d = RUN;
      endcase

      if (rst_i) begin
         // Clearing D and E keeps garbage out of the pipe while reset is held.
         flushD_o = 1'b1;
         flushE_o = 1'b1;
      end else if (freeze) begin
         // E stays held, so a branch or load-use there is re-evaluated on release.
         stallF_o = 1'b1;
         stallD_o = 1'b1;
         stallE_o = 1'b1;
         stallM_o = 1'b1;
         flushW_o = 1'b1;
      end else begin
         // The PC mux takes the redirect target on a taken branch, so holding
         // the PC would lose it: stallF is dropped while stallD still applies.
         stallF_o = lduse & ~pc_srcE_i;
         stallD_o = lduse;
         flushD_o = pc_srcE_i;
         flushE_o = lduse | pc_srcE_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= RUN;
         wait_q      <= '0;
         err_q       <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q <= state_d;

         // Wait counter is zero on entry to MEM_WAIT and stops at TIMEOUT.
         if (state_q == RUN) begin
            wait_q <= '0;
         end else begin
            if (wait_q != WAIT_W'(TIMEOUT)) wait_q <= wait_q + WAIT_W'(1);
            if (wait_q == WAIT_W'(TIMEOUT - 1)) err_q <= 1'b1;
         end

         if (stallF_o && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
         if (pc_srcE_i && !freeze && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
      end
   end

   assign mem_err_o   = err_q;
   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

endmodule
